// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit-side control blocks.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  localparam int DEF_DATA_W = 8;

  // Index width for an n-way select; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotate-priority encoder: grants the first set request at or after ptr,
// searching upward with wrap. Purely combinational.
module rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);

  logic [IW:0]   sum  [N_REQ];
  logic [IW-1:0] cand [N_REQ];
  logic          found;

  // cand[k] is the k-th requester in search order, starting from ptr.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign sum[gi]  = {1'b0, ptr} + (IW+1)'(gi);
    assign cand[gi] = (sum[gi] >= (IW+1)'(N_REQ)) ? IW'(sum[gi] - (IW+1)'(N_REQ))
                                                   : sum[gi][IW-1:0];
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[cand[k]]) begin
        found        = 1'b1;
        gnt[cand[k]] = 1'b1;
        gnt_idx      = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter between N_REQ byte
// producers: accept, launch, wait for busy to rise and fall, then re-arbitrate.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int BUSY_TO = 15,
  localparam int IW      = idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [IW-1:0]           grant_id,
  output logic                    active,
  output logic                    err_timeout,
  input  logic                    err_clr
);

  localparam int CW = $clog2(BUSY_TO + 1);

  tx_state_e         state_reg, state_next;
  logic [IW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]     grant_id_reg, grant_id_next;
  logic [DATA_W-1:0] tx_data_reg, tx_data_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              err_reg, err_next;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              take;
  logic              timeout;
  logic [DATA_W-1:0] data_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_reg),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // rst_n gates the accept so req_ready reads zero while reset is held.
  assign take    = rst_n && (state_reg == IDLE) && !tx_busy && (|req_valid);
  assign timeout = (state_reg == WAIT_BUSY) && !tx_busy && (cnt_reg == CW'(BUSY_TO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (take) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)      state_next = WAIT_DONE;
        else if (timeout) state_next = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = take ? pick_gnt : '0;
    tx_start  = (state_reg == LAUNCH);
    active    = (state_reg != IDLE);
  end

  always_comb begin
    rr_ptr_next   = rr_ptr_reg;
    grant_id_next = grant_id_reg;
    tx_data_next  = tx_data_reg;
    cnt_next      = cnt_reg;
    err_next      = err_reg;
    if (take) begin
      grant_id_next = pick_idx;
      tx_data_next  = data_arr[pick_idx];
      rr_ptr_next   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
    end
    if (state_reg == LAUNCH)
      cnt_next = '0;
    else if ((state_reg == WAIT_BUSY) && !tx_busy)
      cnt_next = cnt_reg + CW'(1);
    // A timeout in the same cycle as err_clr keeps the flag set.
    if (timeout)      err_next = 1'b1;
    else if (err_clr) err_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      tx_data_reg  <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      grant_id_reg <= grant_id_next;
      tx_data_reg  <= tx_data_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
    end
  end

  assign tx_data     = tx_data_reg;
  assign grant_id    = grant_id_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of grant vectors, directed corner cases and
// a randomized run, all checked against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int BTO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy = 1'b0;
  logic [1:0]    grant_id;
  logic          active;
  logic          err_timeout;
  logic          err_clr = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .BUSY_TO(BTO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level reference: one byte in flight, aged in cycles since accept.
  bit      m_inflight;
  int      m_age;
  bit      m_seen;
  int      m_ptr;
  bit      m_err;
  int      m_gid;
  logic [DW-1:0] m_data;

  // Transmitter model and observation hooks.
  int      tx_rem = 0;
  int      frame_len = 100;
  bit      tx_respond = 1'b1;
  bit      force_busy = 1'b0;
  int      last_grant = -1;
  bit      last_start = 1'b0;
  logic [N-1:0] last_ready = '0;
  logic [DW-1:0] tx_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_choose(input logic [N-1:0] v, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] lane(input int i);
    return req_data[i*DW +: DW];
  endfunction

  task automatic model_reset();
    m_inflight = 1'b0; m_age = 0; m_seen = 1'b0; m_ptr = 0;
    m_err = 1'b0; m_gid = 0; m_data = '0;
  endtask

  task automatic set_lanes(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base + DW'(i);
  endtask

  // One clock cycle: entered at a negedge with inputs applied, left at the next.
  task automatic tick();
    int g;
    bit to_now;
    logic [N-1:0] exp_rdy;
    tx_busy = (tx_rem > 0) || force_busy;
    #1;
    if (m_inflight) m_age++;
    last_grant = -1;
    last_start = tx_start;
    last_ready = req_ready;
    g = (!m_inflight && !tx_busy) ? rr_choose(req_valid, m_ptr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("tx_start", tx_start, m_inflight && (m_age == 1));
    chk("active", active, m_inflight);
    chk("err_timeout", err_timeout, m_err);
    chk("grant_id", grant_id, m_gid);
    chk("tx_data", tx_data, m_data);
    if (tx_start) tx_log.push_back(tx_data);
    to_now = 1'b0;
    if (m_inflight && m_age >= 2) begin
      if (m_seen) begin
        if (!tx_busy) m_inflight = 1'b0;
      end else if (tx_busy) begin
        m_seen = 1'b1;
      end else if (m_age - 1 == BTO) begin
        m_inflight = 1'b0;
        to_now = 1'b1;
        $display("txn: timeout on req %0d", m_gid);
      end
    end
    if (to_now) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if (g >= 0) begin
      m_inflight = 1'b1; m_age = 0; m_seen = 1'b0;
      m_gid = g; m_data = lane(g); m_ptr = (g + 1) % N;
      last_grant = g;
      $display("txn: grant req %0d byte %02h", g, lane(g));
    end
    if (tx_start && tx_respond) tx_rem = frame_len;
    else if (tx_rem > 0) tx_rem--;
    @(negedge clk);
  endtask

  task automatic wait_grant(output int g, input int limit);
    g = -1;
    for (int t = 0; t < limit && g < 0; t++) begin
      tick();
      g = last_grant;
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int t = 0; t < limit && active; t++) tick();
    chk("wait_idle", active, 1'b0);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs checked while it is held.
  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ready", req_ready, '0);
    chk("rst_start", tx_start, 1'b0);
    chk("rst_active", active, 1'b0);
    chk("rst_gid", grant_id, '0);
    chk("rst_data", tx_data, '0);
    chk("rst_err", err_timeout, 1'b0);
    model_reset();
    if (tx_rem > 0) tx_rem--;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic [DW-1:0] data;
    int            exp_idx;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, t, starts, ng;
    int cnt [N];
    logic [N-1:0] rdy_acc;
    logic [DW-1:0] exp_order [5];

    // Expected grants from pointer 0 after reset, worked out by hand.
    tbl[0] = '{4'b0100, 8'hA5, 2};
    tbl[1] = '{4'b0011, 8'h20, 0};
    tbl[2] = '{4'b0011, 8'h30, 1};
    tbl[3] = '{4'b1111, 8'h40, 2};
    tbl[4] = '{4'b1111, 8'h50, 3};
    tbl[5] = '{4'b1000, 8'h60, 3};
    tbl[6] = '{4'b0110, 8'h70, 1};
    tbl[7] = '{4'b0011, 8'h80, 0};
    tbl[8] = '{4'b0011, 8'h90, 1};

    model_reset();
    repeat (3) @(negedge clk);
    chk("init_ready", req_ready, '0);
    chk("init_start", tx_start, 1'b0);
    chk("init_active", active, 1'b0);
    chk("init_gid", grant_id, '0);
    chk("init_data", tx_data, '0);
    chk("init_err", err_timeout, 1'b0);
    rst_n = 1'b1;

    // Table-driven grant sequence, including single requester 2 with 0xA5.
    frame_len = 100;
    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].valid;
      set_lanes(tbl[i].data);
      wait_grant(g, 300);
      chk("tbl_grant", g, tbl[i].exp_idx);
      chk("tbl_gid", grant_id, tbl[i].exp_idx);
      chk("tbl_start", tx_start, 1'b1);
      chk("tbl_byte", tx_data, tbl[i].data + DW'(tbl[i].exp_idx));
      req_valid = '0;
      wait_idle(300);
    end

    // All requesters continuously valid: strict rotation.
    pulse_reset();
    frame_len = 20;
    tx_log.delete();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    req_valid = 4'hF;
    set_lanes(8'h10);
    ng = 0;
    for (t = 0; t < 1000 && ng < 5; t++) begin
      tick();
      if (last_grant >= 0) begin
        if (ng < 4) cnt[last_grant]++;
        ng++;
      end
    end
    tick();
    exp_order[0] = 8'h10; exp_order[1] = 8'h11; exp_order[2] = 8'h12;
    exp_order[3] = 8'h13; exp_order[4] = 8'h10;
    chk("rr_count", tx_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_order[i]);
    for (int i = 0; i < N; i++) chk("rr_once", cnt[i], 1);
    req_valid = '0;
    wait_idle(300);

    // Transmitter never answers: timeout, clear, pointer kept.
    pulse_reset();
    tx_respond = 1'b0;
    req_valid = 4'b0010;
    wait_grant(g, 20);
    chk("to_grant", g, 1);
    req_valid = '0;
    t = 0;
    while (active && t < 100) begin tick(); t++; end
    chk("to_cycles", t, BTO + 1);
    chk("to_err", err_timeout, 1'b1);
    chk("to_idle", active, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr", err_timeout, 1'b0);
    req_valid = 4'b0110;
    wait_grant(g, 20);
    chk("to_ptr_kept", g, 2);
    req_valid = '0;
    err_clr = 1'b1;
    t = 0;
    while (active && t < 100) begin tick(); t++; end
    chk("to_set_wins", err_timeout, 1'b1);
    err_clr = 1'b0;
    tick();
    tx_respond = 1'b1;

    // Busy held externally while idle: no grants until it drops.
    force_busy = 1'b1;
    req_valid = 4'b1001;
    rdy_acc = '0;
    for (int i = 0; i < 10; i++) begin tick(); rdy_acc |= last_ready; end
    chk("busy_no_ready", rdy_acc, '0);
    force_busy = 1'b0;
    wait_grant(g, 20);
    chk("busy_release", g, 3);
    req_valid = '0;
    wait_idle(300);

    // Reset during WAIT_DONE: no launch while the frame is still on the wire.
    frame_len = 40;
    req_valid = 4'b0001;
    wait_grant(g, 20);
    for (t = 0; t < 50 && !(tx_busy && active); t++) tick();
    repeat (3) tick();
    chk("wd_active", active, 1'b1);
    pulse_reset();
    starts = 0;
    rdy_acc = '0;
    for (t = 0; t < 200 && tx_rem > 0; t++) begin
      tick();
      starts += int'(last_start);
      rdy_acc |= last_ready;
    end
    chk("wd_no_start", starts, 0);
    chk("wd_no_ready", rdy_acc, '0);
    wait_grant(g, 20);
    chk("wd_regrant", g, 0);
    req_valid = '0;
    wait_idle(300);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) req_valid = N'($urandom);
      if ($urandom_range(0, 3) == 0) req_data = (N*DW)'($urandom);
      force_busy = ($urandom_range(0, 19) == 0);
      err_clr    = ($urandom_range(0, 9) == 0);
      tx_respond = ($urandom_range(0, 9) != 0);
      frame_len  = $urandom_range(1, 6);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
